rv32_wb_arbiter: RTL
====================

RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, depth of the long-latency-unit result buffer (power of two, >=2).
REQ-002 Parameter: STARVE_LIMIT, default 3, consecutive pipeline-won cycles tolerated while the buffer is non-empty.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush_in  input  1  hazard flush; kills the pipeline writeback candidate this cycle.
REQ-006 pipe_valid_in / pipe_rd_write_in  input  1 each  pipeline writeback instruction valid / writes rd.
REQ-007 pipe_rd_in  input  5; pipe_rd_value_in  input  32  pipeline destination register and value.
REQ-008 lu_issue_in  input  1; lu_issue_rd_in  input  5  long-latency op issued, marks rd pending.
REQ-009 lu_valid_in  input  1; lu_rd_in  input  5; lu_rd_value_in  input  32  long-latency result offer.
REQ-010 lu_ready_out  output  1  buffer can accept a result this cycle.
REQ-011 rs1_in, rs2_in, rdq_in  input  5 each  decode-stage hazard query registers.
REQ-012 hazard_out  output  1  any queried register is pending.
REQ-013 pipe_stall_out  output  1  pipeline writeback must hold its inputs stable.
REQ-014 rd_write_out  output  1; rd_out  output  5; rd_value_out  output  32  registered register-file write port.

Function
REQ-015 Pipeline candidate = pipe_valid_in && pipe_rd_write_in && !flush_in && !pipe_stall_out.
REQ-016 LU handshake: result pushed into the buffer at posedge when lu_valid_in && lu_ready_out; lu_ready_out = (count != FIFO_DEPTH), derived from registered count only.
REQ-017 Grant priority each cycle: pipeline candidate first; otherwise buffer head if count != 0; otherwise no write.
REQ-018 Buffer head popped at the posedge it is granted; push and pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-019 Write port registered: granted rd/value appear on rd_out/rd_value_out one cycle after grant; rd_write_out = 1 only if a grant occurred and rd != 0.
REQ-020 Non-granted cycle: rd_write_out = 0, rd_out and rd_value_out hold previous values.
REQ-021 Starvation counter (2-bit saturating): increments when count != 0 and pipeline wins; clears on any buffer pop or when count == 0.
REQ-022 pipe_stall_out = (starve counter == STARVE_LIMIT) && (count != 0), combinational from registers; while asserted the buffer head is granted.
REQ-023 Pending scoreboard: 32-bit mask; lu_issue_in sets bit lu_issue_rd_in (bit 0 never set); a buffer pop clears bit of the popped rd.
REQ-024 Simultaneous set and clear of the same bit: set wins.
REQ-025 hazard_out = pending[rs1_in] | pending[rs2_in] | pending[rdq_in], combinational.
REQ-026 flush_in affects only the pipeline candidate; buffer contents, scoreboard and starve counter unaffected.
REQ-027 Pushes into a full buffer cannot occur; lu_valid_in while lu_ready_out = 0 is held by the producer, no loss.

Reset
REQ-028 On reset assertion (asynchronously, mid-operation included): count, pointers, starve counter, pending mask cleared; rd_write_out = 0, rd_out = 0, rd_value_out = 0; lu_ready_out = 1, pipe_stall_out = 0, hazard_out = 0 (for cleared mask).
REQ-029 Buffered results discarded on reset; no write-port activity until first grant after release.

Verification
REQ-030 Pipeline only: pipe write rd=5, value 0xDEADBEEF -> next cycle rd_write_out=1, rd_out=5, rd_value_out=0xDEADBEEF; rd=0 write -> rd_write_out=0.
REQ-031 Conflict: pipe writes x3 while LU pushes x7=0x12345678 -> x3 written first, x7 written following idle cycle; lu_ready_out stays 1.
REQ-032 Starvation: buffer holds x9, pipe writes every cycle -> after 3 pipeline wins pipe_stall_out=1, x9 written next, stall drops, counter 0.
REQ-033 Full buffer: two LU pushes under continuous pipe writes -> lu_ready_out=0; third offer held until pop; no result lost or reordered.
REQ-034 Scoreboard: issue x12 -> hazard_out=1 for rs1_in=12; issue x12 again same cycle as x12 pop -> bit stays set; flush_in during this leaves bit set.
REQ-035 Reset mid-operation with 2 buffered results and pending bits -> all outputs zero, lu_ready_out=1, hazard_out=0, no subsequent write of discarded results.

Source files
------------

// File: rtl/rv32_wb_arbiter.sv
// Writeback arbiter for an RV32 core: merges pipeline writebacks with buffered
// long-latency results into one registered register-file write port.
module rv32_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_in,
    input  logic        pipe_valid_in,
    input  logic        pipe_rd_write_in,
    input  logic [4:0]  pipe_rd_in,
    input  logic [31:0] pipe_rd_value_in,
    input  logic        lu_issue_in,
    input  logic [4:0]  lu_issue_rd_in,
    input  logic        lu_valid_in,
    input  logic [4:0]  lu_rd_in,
    input  logic [31:0] lu_rd_value_in,
    output logic        lu_ready_out,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [4:0]  rdq_in,
    output logic        hazard_out,
    output logic        pipe_stall_out,
    output logic        rd_write_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_value_out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);
    localparam logic [1:0]    STARVE_C = 2'(STARVE_LIMIT);

    logic [4:0]    rd_mem_q  [FIFO_DEPTH];
    logic [31:0]   val_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          rd_write_q;
    logic [4:0]    rd_q;
    logic [31:0]   rd_value_q;

    logic          pipe_cand_s, push_s, pop_s, grant_s, buf_busy_s;
    logic [4:0]    grant_rd_s;
    logic [31:0]   grant_val_s;

    // Grant selection, buffer bookkeeping, starvation and scoreboard next state.
    always_comb begin
        buf_busy_s     = (count_q != {CW{1'b0}});
        lu_ready_out   = (count_q != FULL_C);
        pipe_stall_out = (starve_q == STARVE_C) && buf_busy_s;
        pipe_cand_s    = pipe_valid_in && pipe_rd_write_in && !flush_in && !pipe_stall_out;
        push_s         = lu_valid_in && lu_ready_out;
        pop_s          = !pipe_cand_s && buf_busy_s;
        grant_s        = pipe_cand_s || pop_s;
        grant_rd_s     = rd_mem_q[rd_ptr_q];
        grant_val_s    = val_mem_q[rd_ptr_q];
        count_d        = count_q;
        starve_d       = starve_q;
        pending_d      = pending_q;
        hazard_out     = pending_q[rs1_in] | pending_q[rs2_in] | pending_q[rdq_in];

        if (pipe_cand_s) begin
            grant_rd_s  = pipe_rd_in;
            grant_val_s = pipe_rd_value_in;
        end else begin
            grant_rd_s  = rd_mem_q[rd_ptr_q];
            grant_val_s = val_mem_q[rd_ptr_q];
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_s || !buf_busy_s) begin
            starve_d = 2'd0;
        end else if (starve_q != 2'd3) begin
            starve_d = starve_q + 2'd1;
        end else begin
            starve_d = starve_q;
        end

        // Clear before set so a same-cycle reissue of the popped rd stays pending.
        if (pop_s) begin
            pending_d[rd_mem_q[rd_ptr_q]] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (lu_issue_in && (lu_issue_rd_in != 5'd0)) begin
            pending_d[lu_issue_rd_in] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // State, result buffer and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_mem_q[i]  <= 5'd0;
                val_mem_q[i] <= 32'd0;
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            starve_q   <= 2'd0;
            pending_q  <= 32'd0;
            rd_write_q <= 1'b0;
            rd_q       <= 5'd0;
            rd_value_q <= 32'd0;
        end else begin
            if (push_s) begin
                rd_mem_q[wr_ptr_q]  <= lu_rd_in;
                val_mem_q[wr_ptr_q] <= lu_rd_value_in;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (grant_s) begin
                rd_q       <= grant_rd_s;
                rd_value_q <= grant_val_s;
            end
            rd_write_q <= grant_s && (grant_rd_s != 5'd0);
            count_q    <= count_d;
            starve_q   <= starve_d;
            pending_q  <= pending_d;
        end
    end

    assign rd_write_out = rd_write_q;
    assign rd_out       = rd_q;
    assign rd_value_out = rd_value_q;

endmodule
